// File: rtl/maze_pkg.sv
// Shared maze definitions for the ghost navigation blocks: grid geometry, directions,
// responder states and tile-position helpers.
package maze_pkg;

  localparam int MAZE_X_BITS = 5;
  localparam int MAZE_Y_BITS = 5;
  localparam int POS_W       = MAZE_X_BITS + MAZE_Y_BITS;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic [MAZE_X_BITS-1:0] pos_x(input logic [POS_W-1:0] pos);
    return MAZE_X_BITS'(pos);
  endfunction

  function automatic logic [MAZE_Y_BITS-1:0] pos_y(input logic [POS_W-1:0] pos);
    return MAZE_Y_BITS'(pos >> MAZE_X_BITS);
  endfunction

  function automatic logic [POS_W-1:0] make_pos(input logic [MAZE_Y_BITS-1:0] y,
                                                 input logic [MAZE_X_BITS-1:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/neighbor_addr_gen.sv
// Combinational neighbour address for one direction; coordinates wrap modulo the field
// width and off_grid_o flags a step across the grid edge.
module neighbor_addr_gen
  import maze_pkg::*;
#(
  parameter int GRID_X_BITS = MAZE_X_BITS,
  parameter int GRID_Y_BITS = MAZE_Y_BITS,
  localparam int PW = GRID_X_BITS + GRID_Y_BITS
) (
  input  logic [PW-1:0] pos_i,
  input  dir_t          dir_i,
  output logic [PW-1:0] nbr_o,
  output logic          off_grid_o
);

  logic [GRID_X_BITS-1:0] x, nx;
  logic [GRID_Y_BITS-1:0] y, ny;

  assign x = pos_i[GRID_X_BITS-1:0];
  assign y = pos_i[PW-1:GRID_X_BITS];

  always_comb begin
    nx         = x;
    ny         = y;
    off_grid_o = 1'b0;
    case (dir_i)
      DIR_UP: begin
        ny         = y - GRID_Y_BITS'(1);
        off_grid_o = (y == '0);
      end
      DIR_DOWN: begin
        ny         = y + GRID_Y_BITS'(1);
        off_grid_o = (y == '1);
      end
      DIR_LEFT: begin
        nx         = x - GRID_X_BITS'(1);
        off_grid_o = (x == '0);
      end
      DIR_RIGHT: begin
        nx         = x + GRID_X_BITS'(1);
        off_grid_o = (x == '1);
      end
      default: ;
    endcase
  end

  assign nbr_o = {ny, nx};

endmodule

// File: rtl/maze_neighbor_server.sv
// Maze query responder: reads the four neighbour wall bits of a tile and returns a blocked mask.
// Build option TUNNEL_WRAP_EN: off-grid neighbours are read as tunnels instead of forced blocked.
module maze_neighbor_server
  import maze_pkg::*;
#(
  parameter int GRID_X_BITS = MAZE_X_BITS,
  parameter int GRID_Y_BITS = MAZE_Y_BITS,
  localparam int PW = GRID_X_BITS + GRID_Y_BITS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [PW-1:0]   req_pos,
  output logic            mem_rd_en,
  output logic [PW-1:0]   mem_addr,
  input  logic            mem_rdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [3:0]      rsp_blocked,
  output logic [4*PW-1:0] rsp_nbr_pos
);

`ifdef TUNNEL_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  state_t state_q, state_d;
  logic [1:0] slot_q, slot_d;

  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          mem_rd_en_q, mem_rd_en_d;
  logic [PW-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]    blocked_q, blocked_d;

  logic [3:0][PW-1:0] nbr_q, gen_nbr;
  logic [3:0]         off_q, gen_off;
  logic [1:0]         iss_slot_q, pend_slot_q;
  logic               rd_pend_q;

  logic          accept;
  logic [PW-1:0] rd_addr;
  logic          rd_off;

  for (genvar k = 0; k < 4; k++) begin : g_nbr
    localparam dir_t DIR = dir_t'(k);
    neighbor_addr_gen #(
      .GRID_X_BITS(GRID_X_BITS),
      .GRID_Y_BITS(GRID_Y_BITS)
    ) u_gen (
      .pos_i      (req_pos),
      .dir_i      (DIR),
      .nbr_o      (gen_nbr[k]),
      .off_grid_o (gen_off[k])
    );
  end

  assign accept = (state_q == ST_IDLE) && req_valid && req_ready_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      slot_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_READ;
          slot_d  = 2'd0;
        end
      end
      ST_READ: begin
        if (slot_q == 2'd3) state_d = ST_DRAIN;
        else                slot_d  = slot_q + 2'd1;
      end
      ST_DRAIN: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so slot k is on the memory bus while slot_q == k.
  always_comb begin
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    rd_addr     = accept ? gen_nbr[0] : nbr_q[slot_d];
    rd_off      = accept ? gen_off[0] : off_q[slot_d];
    mem_rd_en_d = (state_d == ST_READ) && (WRAP_EN || !rd_off);
    mem_addr_d  = (state_d == ST_READ) ? rd_addr : mem_addr_q;
    blocked_d   = blocked_q;
    if (accept) begin
      blocked_d = WRAP_EN ? 4'b0000 : gen_off;
    end else if (rd_pend_q) begin
      blocked_d[pend_slot_q] = mem_rdata;
    end
  end

  // rd_pend_q marks the cycle in which the wall bit of pend_slot_q is on mem_rdata.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      blocked_q   <= 4'b0000;
      nbr_q       <= '0;
      off_q       <= 4'b0000;
      iss_slot_q  <= 2'd0;
      pend_slot_q <= 2'd0;
      rd_pend_q   <= 1'b0;
    end else begin
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      blocked_q   <= blocked_d;
      iss_slot_q  <= slot_d;
      pend_slot_q <= iss_slot_q;
      rd_pend_q   <= mem_rd_en_q;
      if (accept) begin
        nbr_q <= gen_nbr;
        off_q <= gen_off;
      end
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_addr    = mem_addr_q;
  assign rsp_blocked = blocked_q;
  assign rsp_nbr_pos = nbr_q;

endmodule

// File: tb/tb_maze_neighbor_server.sv
// Scoreboard bench for maze_neighbor_server: directed queries push expected responses,
// a negedge monitor pops and compares them at each response handshake.
module tb_maze_neighbor_server;
  import maze_pkg::*;

`ifdef TUNNEL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   req_valid;
  logic                   req_ready;
  logic [POS_W-1:0]       req_pos;
  logic                   mem_rd_en;
  logic [POS_W-1:0]       mem_addr;
  logic                   mem_rdata = 1'b0;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [3:0]             rsp_blocked;
  logic [4*POS_W-1:0]     rsp_nbr_pos;

  logic [1023:0] walls;
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic [3:0]         blk;
    logic [4*POS_W-1:0] nbr;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  maze_neighbor_server dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_pos     (req_pos),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_blocked (rsp_blocked),
    .rsp_nbr_pos (rsp_nbr_pos)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= walls[mem_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_blocked", 64'(rsp_blocked), 64'(mon_e.blk));
        chk("rsp_nbr_pos", 64'(rsp_nbr_pos), 64'(mon_e.nbr));
      end
    end
  end

  task automatic run_query(input logic [POS_W-1:0] pos, input logic [3:0] blk,
                           input logic [4*POS_W-1:0] nbr, input logic [3:0] rdm,
                           input int hold, output int t_acc);
    exp_t ex;
    logic [3:0] sblk;
    logic [4*POS_W-1:0] snbr;
    int w;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready_wait", 64'(req_ready), 64'd1);
    ex.blk = blk;
    ex.nbr = nbr;
    sb.push_back(ex);
    rsp_ready = (hold == 0);
    req_pos   = pos;
    req_valid = 1'b1;
    @(posedge clk); #1;
    t_acc     = cyc;
    req_valid = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("rd_en_slot", 64'(mem_rd_en), 64'(rdm[n]));
      if (rdm[n]) chk("rd_addr_slot", 64'(mem_addr), 64'(nbr[n*POS_W +: POS_W]));
    end
    @(negedge clk);
    chk("drain_quiet", 64'({mem_rd_en, rsp_valid}), 64'd0);
    @(negedge clk);
    chk("rsp_latency", 64'(rsp_valid), 64'd1);
    if (hold == 0) begin
      @(negedge clk);
      chk("req_ready_ret", 64'(req_ready), 64'd1);
    end else begin
      sblk = rsp_blocked;
      snbr = rsp_nbr_pos;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk("bp_hold", 64'({rsp_valid, req_ready, rsp_blocked, rsp_nbr_pos}),
            64'({1'b1, 1'b0, sblk, snbr}));
        req_pos   = 10'd160;
        req_valid = 1'b1;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release", 64'({req_ready, rsp_valid}), 64'd2);
      @(negedge clk);
      chk("bp_ignored", 64'(mem_rd_en), 64'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, w;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_pos   = '0;
    rsp_ready = 1'b1;
    walls     = '0;
    #2 reset = 1'b1;
    #1;
    chk("rst_outputs", 64'({req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_blocked}), 64'd0);
    chk("rst_nbr", 64'(rsp_nbr_pos), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_ready_low", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(req_ready), 64'd1);

    // Interior tile x=10 y=12, walls above and to the right.
    walls[362] = 1'b1;
    walls[395] = 1'b1;
    run_query(make_pos(5'd12, 5'd10), 4'b1001,
              {10'd395, 10'd393, 10'd426, 10'd362}, 4'b1111, 0, t1);

    // Left edge x=0 y=5: left neighbour wraps to 191.
    run_query(10'd160, WRAP ? 4'b0000 : 4'b0100,
              {10'd161, 10'd191, 10'd192, 10'd128}, WRAP ? 4'b1111 : 4'b1011, 0, t1);

    // Bottom-right corner: right wraps to 992, down wraps to 31, both walled.
    walls[992] = 1'b1;
    walls[31]  = 1'b1;
    run_query(10'd1023, 4'b1010,
              {10'd992, 10'd1022, 10'd31, 10'd991}, WRAP ? 4'b1111 : 4'b0101, 0, t1);

    // Backpressure for three cycles with an extra request that must be ignored.
    run_query(10'd394, 4'b1001, {10'd395, 10'd393, 10'd426, 10'd362}, 4'b1111, 3, t1);

    // Back-to-back queries at peak rate.
    run_query(10'd394, 4'b1001, {10'd395, 10'd393, 10'd426, 10'd362}, 4'b1111, 0, t1);
    run_query(10'd160, WRAP ? 4'b0000 : 4'b0100,
              {10'd161, 10'd191, 10'd192, 10'd128}, WRAP ? 4'b1111 : 4'b1011, 0, t2);
    chk("b2b_accept_gap", 64'(t2 - t1), 64'd7);

    // Reset in the middle of the READ phase.
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    req_pos   = 10'd394;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_outputs", 64'({req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_blocked}), 64'd0);
    chk("abort_nbr", 64'(rsp_nbr_pos), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_rd", 64'({mem_rd_en, rsp_valid}), 64'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_ready_low", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    chk("abort_ready_back", 64'({req_ready, rsp_valid}), 64'd2);

    run_query(10'd394, 4'b1001, {10'd395, 10'd393, 10'd426, 10'd362}, 4'b1111, 0, t1);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
